histogram_readout: RTL and testbench

- Read-side engine for the histogram bin RAM: on a frame-end Start pulse, takes the RAM's single port, sweeps bins 0..NUM_BINS-1 and streams each bin count out on a valid/ready interface.
- Optionally clears each bin to zero in the same cycle it is read, leaving the RAM empty for the next frame.
- Also reports the total of all counts for the frame.
- Sits between the bin RAM (24-bit words, 1024 deep, 1-cycle registered read with ClockEn) and the downstream packetiser.

---
 rtl/histogram_readout_if.sv | 15 +
 rtl/histogram_readout.sv | 144 ++++++++++++++
 tb/tb_histogram_readout.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/histogram_readout_if.sv
// Output stream of the histogram readout engine: one bin count per handshake,
// tagged with its bin index and an end-of-frame marker.
interface histogram_readout_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 24
);
  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_WIDTH-1:0] OutData;
  logic [ADDR_WIDTH-1:0] OutBin;
  logic                  OutLast;

  modport master (output OutValid, OutData, OutBin, OutLast, input OutReady);
  modport slave  (input OutValid, OutData, OutBin, OutLast, output OutReady);
endinterface

// File: rtl/histogram_readout.sv
// Frame-end sweep of the histogram bin RAM: streams every bin in index order,
// optionally zeroes each bin as it is read, and reports the frame total.
module histogram_readout #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 24,
  parameter int NUM_BINS      = 1024,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic                             Clock,
  input  logic                             Reset_n,
  input  logic                             Start,
  output logic                             Busy,
  output logic                             Done,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] FrameSum,
  output logic                             RamClockEn,
  output logic                             RamWE,
  output logic [ADDR_WIDTH-1:0]            RamAddress,
  output logic [DATA_WIDTH-1:0]            RamData,
  input  logic [DATA_WIDTH-1:0]            RamQ,
  histogram_readout_if.master              stream
);

  localparam int SW = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] fl_bin;
  logic [1:0]            fcnt;
  logic                  rp, wp;
  logic [DATA_WIDTH-1:0] fdata [2];
  logic [ADDR_WIDTH-1:0] fbin  [2];
  logic [SW-1:0]         acc, acc_nxt;

  logic                  issue, start_ok, drained;
  logic                  fifo_ne, valid, push, pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] head_bin;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Issue only counts words already owned (buffered + in flight), never OutReady,
  // so the 2-entry buffer always has room for whatever RamQ returns.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_ok  = 1'b0;
    drained   = 1'b0;
    case (state)
      IDLE: if (Start) begin
        start_ok  = 1'b1;
        state_nxt = SWEEP;
      end
      SWEEP: begin
        issue = (fcnt + {1'b0, inflight}) < 2'd2;
        if (issue && ptr == LAST_BIN) state_nxt = DRAIN;
      end
      DRAIN: if (fcnt == 2'd0 && !inflight) begin
        drained   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy       = (state == SWEEP) || (state == DRAIN && !drained);
  assign Done       = drained;
  assign RamClockEn = issue;
  assign RamWE      = CLEAR_ON_READ ? issue : 1'b0;
  assign RamAddress = issue ? ptr : '0;
  assign RamData    = '0;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr      <= '0;
      inflight <= 1'b0;
      fl_bin   <= '0;
    end else begin
      inflight <= issue;
      if (issue) fl_bin <= ptr;
      if (start_ok)                     ptr <= '0;
      else if (issue && ptr != LAST_BIN) ptr <= ptr + 1'b1;
    end
  end

  // The word returning on RamQ bypasses the empty buffer so the head is
  // visible in the same cycle it arrives; it is only stored if not taken.
  assign fifo_ne   = fcnt != 2'd0;
  assign valid     = fifo_ne || inflight;
  assign head_data = fifo_ne ? fdata[rp] : RamQ;
  assign head_bin  = fifo_ne ? fbin[rp]  : fl_bin;
  assign pop       = fifo_ne && stream.OutReady;
  assign push      = inflight && !(!fifo_ne && stream.OutReady);

  assign stream.OutValid = valid;
  assign stream.OutData  = valid ? head_data : '0;
  assign stream.OutBin   = valid ? head_bin  : '0;
  assign stream.OutLast  = valid && (head_bin == LAST_BIN);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      fcnt <= 2'd0;
      rp   <= 1'b0;
      wp   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fdata[i] <= '0;
        fbin[i]  <= '0;
      end
    end else begin
      if (push) begin
        fdata[wp] <= RamQ;
        fbin[wp]  <= fl_bin;
        wp        <= ~wp;
      end
      if (pop) rp <= ~rp;
      fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    acc_nxt = acc;
    if (start_ok)      acc_nxt = '0;
    else if (inflight) acc_nxt = acc + SW'(RamQ);
  end

  // FrameSum follows the accumulator only while draining, so it settles on the
  // final total by the Done cycle and then holds through the next sweep.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      acc      <= '0;
      FrameSum <= '0;
    end else begin
      acc <= acc_nxt;
      if (state == DRAIN) FrameSum <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_histogram_readout.sv
// Bench for histogram_readout: two instances (clear / no-clear) on behavioural
// bin RAMs, table of sweeps plus mid-sweep restart and reset sequences.
module tb_histogram_readout;
  localparam int NB = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_s[2], rdy[2], load_req[2];
  logic        busy[2], done[2], ce[2], we[2], vld[2], last[2];
  logic [9:0]  addr[2], bin[2];
  logic [23:0] wdata[2], q[2], odata[2];
  logic [33:0] fsum[2];

  logic [23:0] ram [2][NB];
  logic [23:0] img [NB];
  logic [23:0] snap [NB];

  histogram_readout_if #(.ADDR_WIDTH(10), .DATA_WIDTH(24)) if0();
  histogram_readout_if #(.ADDR_WIDTH(10), .DATA_WIDTH(24)) if1();

  assign if0.OutReady = rdy[0];
  assign if1.OutReady = rdy[1];
  assign vld[0] = if0.OutValid; assign odata[0] = if0.OutData;
  assign bin[0] = if0.OutBin;   assign last[0]  = if0.OutLast;
  assign vld[1] = if1.OutValid; assign odata[1] = if1.OutData;
  assign bin[1] = if1.OutBin;   assign last[1]  = if1.OutLast;

  histogram_readout #(.CLEAR_ON_READ(1'b1)) dut0 (
    .Clock(clk), .Reset_n(rst_n), .Start(start_s[0]), .Busy(busy[0]), .Done(done[0]),
    .FrameSum(fsum[0]), .RamClockEn(ce[0]), .RamWE(we[0]), .RamAddress(addr[0]),
    .RamData(wdata[0]), .RamQ(q[0]), .stream(if0));

  histogram_readout #(.CLEAR_ON_READ(1'b0)) dut1 (
    .Clock(clk), .Reset_n(rst_n), .Start(start_s[1]), .Busy(busy[1]), .Done(done[1]),
    .FrameSum(fsum[1]), .RamClockEn(ce[1]), .RamWE(we[1]), .RamAddress(addr[1]),
    .RamData(wdata[1]), .RamQ(q[1]), .stream(if1));

  // Read-before-write single-port RAM with registered output.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (load_req[d]) begin
        for (int i = 0; i < NB; i++) ram[d][i] <= img[i];
      end else if (ce[d]) begin
        q[d] <= ram[d][addr[d]];
        if (we[d]) ram[d][addr[d]] <= wdata[d];
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit all_zero(input int d);
    return !(busy[d] | done[d] | vld[d] | last[d] | ce[d] | we[d]) &&
           addr[d] == 10'd0 && bin[d] == 10'd0 && odata[d] == 24'd0 && fsum[d] == 34'd0;
  endfunction

  task automatic load(input int d, input int pat);
    for (int i = 0; i < NB; i++)
      img[i] = (pat == 0) ? 24'(i + 1) : (pat == 1) ? 24'hFFFFFF : 24'($urandom);
    @(negedge clk); load_req[d] = 1'b1;
    @(negedge clk); load_req[d] = 1'b0;
  endtask

  int     r_words, r_werr, r_stab, r_oerr, r_weerr, r_ndone, r_first, r_done;
  bit     r_busy1, r_busy_after, r_zero_rst;
  longint r_sum;

  // Expected stream: bins 0..NB-1 in order, each carrying the RAM content
  // captured at Start; only one Done, at most 2 words outstanding.
  task automatic sweep(input int d, input int rdy_pct, input int restart_bin, input int abort_cyc);
    int nxt = 0, outst = 0, done_cyc = -1;
    bit held = 0, restarted = 0;
    logic [23:0] hd = '0;
    logic [9:0]  hb = '0;
    r_words = 0; r_werr = 0; r_stab = 0; r_oerr = 0; r_weerr = 0; r_ndone = 0;
    r_first = -1; r_busy1 = 0; r_busy_after = 1; r_sum = -1; r_zero_rst = 0;
    for (int i = 0; i < NB; i++) snap[i] = ram[d][i];
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == abort_cyc) begin
        rst_n = 1'b0;
        #1 r_zero_rst = all_zero(d);
        break;
      end
      start_s[d] = (c == 0);
      if (!restarted && restart_bin >= 0 && nxt == restart_bin) begin
        start_s[d] = 1'b1; restarted = 1;
      end
      rdy[d] = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (c == 1) r_busy1 = busy[d];
      if (done_cyc >= 0 && c == done_cyc + 1) r_busy_after = busy[d];
      if (ce[d] && outst >= 2) r_oerr++;
      if (we[d] !== ((d == 0) ? ce[d] : 1'b0)) r_weerr++;
      if (held && (!vld[d] || odata[d] !== hd || bin[d] !== hb)) r_stab++;
      held = 0;
      if (vld[d]) begin
        if (r_first < 0) r_first = c;
        if (nxt >= NB || bin[d] !== 10'(nxt) || odata[d] !== snap[nxt] || last[d] !== (nxt == NB - 1))
          r_werr++;
        if (rdy[d]) begin nxt++; r_words++; end
        else begin held = 1; hd = odata[d]; hb = bin[d]; end
      end
      if (ce[d]) outst++;
      if (vld[d] && rdy[d]) outst--;
      if (done[d]) begin
        r_ndone++;
        if (done_cyc < 0) begin done_cyc = c; r_sum = longint'(fsum[d]); end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start_s[d] = 1'b0;
    rdy[d] = 1'b1;
    r_done = done_cyc;
  endtask

  task automatic judge(input string tag, input int d, input longint exp_sum, input int exp_done);
    int rerr = 0;
    longint msum = 0;
    for (int i = 0; i < NB; i++) begin
      msum += longint'(snap[i]);
      if (ram[d][i] !== ((d == 0) ? 24'h0 : snap[i])) rerr++;
    end
    check({tag, ".words"}, r_words, NB);
    check({tag, ".order"}, r_werr, 0);
    check({tag, ".stable"}, r_stab, 0);
    check({tag, ".outstanding"}, r_oerr, 0);
    check({tag, ".we"}, r_weerr, 0);
    check({tag, ".done_count"}, r_ndone, 1);
    check({tag, ".first_valid"}, r_first, 2);
    check({tag, ".busy"}, {r_busy1, r_busy_after}, 2'b10);
    check({tag, ".sum"}, r_sum, (exp_sum >= 0) ? exp_sum : msum);
    if (exp_done >= 0) check({tag, ".done_lat"}, r_done, exp_done);
    check({tag, ".ram_after"}, rerr, 0);
  endtask

  typedef struct {
    int     d;
    int     pct;
    int     pat;       // -1: keep RAM contents from the previous sweep
    int     restart;   // bin at which a stray Start is pulsed, -1 none
    longint sum;       // -1: use the model sum of the snapshot
    int     done_lat;  // -1: not fixed (back-pressure)
  } vec_t;

  vec_t tbl[7];

  initial begin
    int errs;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin start_s[d] = 0; rdy[d] = 1; load_req[d] = 0; end
    tbl[0] = '{0, 100,  0,  -1, 64'd524800,      1026};
    tbl[1] = '{0,  70,  0,  -1, 64'd524800,      -1};
    tbl[2] = '{0, 100,  1,  -1, 64'h3FFFFFC00,   1026};
    tbl[3] = '{1, 100,  0,  -1, 64'd524800,      1026};
    tbl[4] = '{1, 100, -1,  -1, 64'd524800,      1026};
    tbl[5] = '{0, 100,  0, 300, 64'd524800,      1026};
    tbl[6] = '{0,  60,  2,  -1, -64'sd1,         -1};

    repeat (2) @(negedge clk);
    #1 check("reset_state", {all_zero(0), all_zero(1)}, 2'b11);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      if (tbl[k].pat >= 0) load(tbl[k].d, tbl[k].pat);
      sweep(tbl[k].d, tbl[k].pct, tbl[k].restart, -1);
      judge($sformatf("row%0d", k), tbl[k].d, tbl[k].sum, tbl[k].done_lat);
      repeat (3) @(negedge clk);
    end

    // Reset while bin 500 is on the output: bins 0..500 have been issued and cleared.
    load(0, 0);
    sweep(0, 100, -1, 502);
    check("midsweep_reset.outputs", r_zero_rst, 1);
    errs = 0;
    for (int i = 0; i < NB; i++)
      if (ram[0][i] !== ((i <= 500) ? 24'h0 : 24'(i + 1))) errs++;
    check("midsweep_reset.ram", errs, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sweep(0, 100, -1, -1);
    judge("post_reset", 0, 64'd399049, 1026);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
